// File: rtl/bcd_scan_driver_if.sv
// Load/convert request and multiplexed display bus between a controller
// and the BCD scan driver.
interface bcd_scan_driver_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic              load;
  logic [BIN_W-1:0]  bin_in;
  logic              busy;
  logic              done;
  logic              ovf;
  logic [3:0]        digit;
  logic [DIGITS-1:0] an;

  modport master (
    output load, bin_in,
    input  busy, done, ovf, digit, an
  );

  modport slave (
    input  load, bin_in,
    output busy, done, ovf, digit, an
  );
endinterface

// File: rtl/bcd_scan_driver.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a free-running
// time-multiplexed digit scan for a 7-segment decoder.
module bcd_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int BIN_W       = 14,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input logic             clk,
  input logic             rst,
  bcd_scan_driver_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);
  localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 2) ? $clog2(DIGITS) : 1;

  localparam logic [BIN_W-1:0]  MAX_VAL   = BIN_W'(9999);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BIN_W - 1);
  localparam logic [REF_W-1:0]  REF_MAX   = REF_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_ONE    = {{(DIGITS-1){1'b0}}, 1'b1};
  localparam logic [BCD_W-1:0]  RST_DISP  = (BLANK_LZ != 0) ?
                                            {{(DIGITS-1){4'hF}}, 4'h0} : '0;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_q;
  logic [BIN_W-1:0]    binSr_q;
  logic [BCD_W-1:0]    bcd_q;
  logic [CNT_W-1:0]    count_q;
  logic                busy_q;
  logic                done_q;
  logic                ovf_q;
  logic [BCD_W-1:0]    disp_q;

  logic [REF_W-1:0]    refCnt_q, refCnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIGITS-1:0]   an_q;
  logic [3:0]          digit_q;

  logic [BCD_W-1:0]       bcdAdj;
  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       bcd_d;
  logic [BIN_W-1:0]       binSr_d;

  // Leading zeros above the most significant nonzero digit become blank;
  // digit 0 always shows.
  function automatic logic [BCD_W-1:0] blankDigits(input logic [BCD_W-1:0] raw);
    logic [BCD_W-1:0] res;
    logic             lead;
    res  = raw;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (raw[4*i +: 4] == 4'h0)) begin
        res[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
    return res;
  endfunction

  always_comb begin
    bcdAdj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcdAdj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {bcdAdj, binSr_q} << 1;
    bcd_d   = shifted[BCD_W+BIN_W-1:BIN_W];
    binSr_d = shifted[BIN_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      binSr_q <= '0;
      bcd_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      disp_q  <= RST_DISP;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.load) begin
            // Out-of-range values never enter the converter.
            if (bus.bin_in > MAX_VAL) begin
              disp_q <= '1;
              ovf_q  <= 1'b1;
              done_q <= 1'b1;
            end else begin
              binSr_q <= bus.bin_in;
              bcd_q   <= '0;
              count_q <= '0;
              busy_q  <= 1'b1;
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          bcd_q   <= bcd_d;
          binSr_q <= binSr_d;
          count_q <= count_q + CNT_W'(1);
          if (count_q == LAST_CNT) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ovf_q   <= 1'b0;
            disp_q  <= (BLANK_LZ != 0) ? blankDigits(bcd_d) : bcd_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    refCnt_d = (refCnt_q == REF_MAX) ? '0 : refCnt_q + REF_W'(1);
    idx_d    = idx_q;
    if (refCnt_q == REF_MAX) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Digit is reloaded every cycle so a display update shows up one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refCnt_q <= '0;
      idx_q    <= '0;
      an_q     <= ~AN_ONE;
      digit_q  <= 4'h0;
    end else begin
      refCnt_q <= refCnt_d;
      idx_q    <= idx_d;
      an_q     <= ~(AN_ONE << idx_d);
      digit_q  <= disp_q[4*idx_d +: 4];
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.ovf   = ovf_q;
  assign bus.digit = digit_q;
  assign bus.an    = an_q;

endmodule
